// File: rtl/acc_frame_serializer.sv
// acc_frame_serializer: drains one storage record into a framed byte stream
// (sync, seq, length, payload[, checksum]). Define FRAME_CHECKSUM_EN to append the checksum byte.
module acc_frame_serializer #(
  parameter int unsigned PAYLOAD_BYTES = 1024,
  parameter int unsigned READ_LATENCY  = 2,
  parameter logic [7:0]  SYNC0         = 8'hA5,
  parameter logic [7:0]  SYNC1         = 8'h5A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] src_data,
  input  logic       src_ready,
  output logic       src_rd,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort,
  output logic [7:0] seq_num
);

  localparam logic [15:0] LEN_W    = 16'(PAYLOAD_BYTES);
  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_BYTES - 1);
  localparam logic [3:0]  LAT_LOAD = 4'(READ_LATENCY);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SYNC_A = 4'd1,
    ST_SYNC_B = 4'd2,
    ST_SEQ    = 4'd3,
    ST_LEN_H  = 4'd4,
    ST_LEN_L  = 4'd5,
    ST_FETCH  = 4'd6,
    ST_PAY    = 4'd7,
    ST_DONE   = 4'd8
`ifdef FRAME_CHECKSUM_EN
    , ST_CSUM = 4'd9
`endif
  } state_t;

`ifdef FRAME_CHECKSUM_EN
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  function automatic logic [7:0] csum_neg(input logic [7:0] acc);
    return (~acc) + 8'd1;
  endfunction
`endif

  state_t      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        src_rd_q, src_rd_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_abort_q, frame_abort_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  lat_q, lat_d;
  logic        abort_pend_q, abort_pend_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic xfer_s;
  logic last_s;
  logic abort_req_s;

  assign xfer_s      = tx_valid_q & tx_ready;
  assign last_s      = (cnt_q == LAST_IDX);
  // A drop of src_ready is remembered so the byte already on tx can finish first.
  assign abort_req_s = abort_pend_q | ~src_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && src_ready) state_d = ST_SYNC_A;
        else                     state_d = ST_IDLE;
      end
      ST_SYNC_A: begin
        if (xfer_s) state_d = abort_req_s ? ST_IDLE : ST_SYNC_B;
        else        state_d = ST_SYNC_A;
      end
      ST_SYNC_B: begin
        if (xfer_s) state_d = abort_req_s ? ST_IDLE : ST_SEQ;
        else        state_d = ST_SYNC_B;
      end
      ST_SEQ: begin
        if (xfer_s) state_d = abort_req_s ? ST_IDLE : ST_LEN_H;
        else        state_d = ST_SEQ;
      end
      ST_LEN_H: begin
        if (xfer_s) state_d = abort_req_s ? ST_IDLE : ST_LEN_L;
        else        state_d = ST_LEN_H;
      end
      ST_LEN_L: begin
        if (xfer_s) state_d = abort_req_s ? ST_IDLE : ST_FETCH;
        else        state_d = ST_LEN_L;
      end
      ST_FETCH: begin
        if (abort_req_s)          state_d = ST_IDLE;
        else if (lat_q == 4'd0)   state_d = ST_PAY;
        else                      state_d = ST_FETCH;
      end
      ST_PAY: begin
        // Once the final byte is fetched the record is drained; src_ready no longer matters.
        if (xfer_s && last_s) begin
`ifdef FRAME_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end else if (xfer_s) begin
          state_d = abort_req_s ? ST_IDLE : ST_FETCH;
        end else begin
          state_d = ST_PAY;
        end
      end
`ifdef FRAME_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer_s) state_d = ST_DONE;
        else        state_d = ST_CSUM;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-values; every output is loaded into a register.
  always_comb begin
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q & ~xfer_s;
    src_rd_d      = 1'b0;
    cnt_d         = cnt_q;
    seq_d         = seq_q;
    lat_d         = (lat_q == 4'd0) ? 4'd0 : (lat_q - 4'd1);
    abort_pend_d  = (state_d != ST_IDLE) & abort_req_s;
    frame_done_d  = (state_d == ST_DONE) & (state_q != ST_DONE);
    frame_abort_d = (state_d == ST_IDLE) & (state_q != ST_IDLE) & (state_q != ST_DONE);
    busy_d        = (state_d != ST_IDLE);
`ifdef FRAME_CHECKSUM_EN
    if (xfer_s && ((state_q == ST_SEQ) || (state_q == ST_LEN_H) ||
                   (state_q == ST_LEN_L) || (state_q == ST_PAY))) begin
      csum_d = csum_add(csum_q, tx_data_q);
    end else begin
      csum_d = csum_q;
    end
`endif
    if ((state_q == ST_PAY) && xfer_s) cnt_d = cnt_q + 16'd1;
    else                               cnt_d = cnt_q;
    if (state_q == ST_DONE) seq_d = seq_q + 8'd1;
    else                    seq_d = seq_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_SYNC_A: begin
          tx_data_d  = SYNC0;
          tx_valid_d = 1'b1;
          cnt_d      = 16'd0;
          lat_d      = 4'd0;
`ifdef FRAME_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
        ST_SYNC_B: begin
          tx_data_d  = SYNC1;
          tx_valid_d = 1'b1;
        end
        ST_SEQ: begin
          tx_data_d  = seq_q;
          tx_valid_d = 1'b1;
        end
        ST_LEN_H: begin
          tx_data_d  = LEN_W[15:8];
          tx_valid_d = 1'b1;
        end
        ST_LEN_L: begin
          tx_data_d  = LEN_W[7:0];
          tx_valid_d = 1'b1;
        end
        ST_PAY: begin
          tx_data_d  = src_data;
          tx_valid_d = 1'b1;
          src_rd_d   = 1'b1;
          lat_d      = LAT_LOAD;
        end
`ifdef FRAME_CHECKSUM_EN
        ST_CSUM: begin
          tx_data_d  = csum_neg(csum_d);
          tx_valid_d = 1'b1;
        end
`endif
        default: tx_valid_d = tx_valid_q & ~xfer_s;
      endcase
    end else begin
      tx_data_d = tx_data_q;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q     <= 8'd0;
      tx_valid_q    <= 1'b0;
      src_rd_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      seq_q         <= 8'd0;
      cnt_q         <= 16'd0;
      lat_q         <= 4'd0;
      abort_pend_q  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum_q        <= 8'd0;
`endif
    end else begin
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      src_rd_q      <= src_rd_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      seq_q         <= seq_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      abort_pend_q  <= abort_pend_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign src_rd      = src_rd_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign seq_num     = seq_q;

endmodule

// File: tb/tb_acc_frame_serializer.sv
// Directed bench for acc_frame_serializer with a 4-byte record and a latency-2 storage model.
module tb_acc_frame_serializer;

  localparam int PB = 4;
  localparam int RL = 2;
`ifdef FRAME_CHECKSUM_EN
  localparam int FL = PB + 6;
`else
  localparam int FL = PB + 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n, enable, src_ready, tx_ready;
  logic       src_rd, tx_valid, busy, frame_done, frame_abort;
  logic [7:0] src_data, tx_data, seq_num;

  always #5 clk = ~clk;

  acc_frame_serializer #(.PAYLOAD_BYTES(PB), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .src_data(src_data),
    .src_ready(src_ready), .src_rd(src_rd), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done), .frame_abort(frame_abort), .seq_num(seq_num)
  );

  // Storage model: record bytes 01..04, advanced by src_rd.
  logic [1:0] rd_idx;
  assign src_data = {6'd0, rd_idx} + 8'd1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_idx <= 2'd0;
    else if (src_rd) rd_idx <= rd_idx + 2'd1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, rd_cnt = 0, last_rd = 0, gap_err = 0, done_cnt = 0, abort_cnt = 0;
  int stab_err = 0, valid_cnt = 0, busy_cnt = 0;
  logic [7:0] cap[$];
  bit         held = 1'b0;
  logic [7:0] held_d = 8'd0;

  // Bus monitor: captured bytes, src_rd spacing and hold-while-stalled behaviour.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_rd) begin
      if (rd_cnt > 0 && (cyc - last_rd) < RL + 1) gap_err <= gap_err + 1;
      rd_cnt  <= rd_cnt + 1;
      last_rd <= cyc;
    end
    if (tx_valid && tx_ready) cap.push_back(tx_data);
    if (tx_valid) valid_cnt <= valid_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_abort) abort_cnt <= abort_cnt + 1;
    if (held && rst_n && !(tx_valid && tx_data == held_d)) stab_err <= stab_err + 1;
    held   <= rst_n && tx_valid && !tx_ready;
    held_d <= tx_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_end(input bit toggle, input int drop_rd, input int drop_en_rd,
                          input int rd_base, output bit timed_out, output logic busy_end);
    timed_out = 1'b1;
    busy_end  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (toggle) tx_ready = ~tx_ready;
      if (drop_rd > 0 && (rd_cnt - rd_base) == drop_rd) src_ready = 1'b0;
      if (drop_en_rd > 0 && (rd_cnt - rd_base) == drop_en_rd) enable = 1'b0;
      if (frame_done || frame_abort) begin
        timed_out = 1'b0;
        busy_end  = busy;
        break;
      end
    end
    src_ready = 1'b0;
    tx_ready  = 1'b1;
  endtask

  logic [7:0] exp1 [0:9] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
  logic [7:0] exp2 [0:9] = '{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF1};
  logic [7:0] exp3 [0:6] = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h04, 8'h01, 8'h02};

  int   b, rb, db, ab, vb, bb, sb, nd;
  bit   to, pend, fin;
  logic bz;

  initial begin
    rst_n = 1'b0; enable = 1'b0; src_ready = 1'b0; tx_ready = 1'b1;
    #12;
    check_eq("rst_src_rd", src_rd, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_frame_abort", frame_abort, 0);
    check_eq("rst_seq_num", seq_num, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal frame, tx_ready held high.
    b = cap.size(); rb = rd_cnt; db = done_cnt;
    enable = 1'b1; src_ready = 1'b1;
    wait_end(1'b0, 0, 0, rb, to, bz);
    check_eq("t1_timeout", to, 0);
    repeat (3) @(negedge clk);
    check_eq("t1_len", cap.size() - b, FL);
    for (int i = 0; i < FL; i++) check_eq("t1_byte", cap[b + i], exp1[i]);
    check_eq("t1_rd_pulses", rd_cnt - rb, PB);
    check_eq("t1_rd_gap", gap_err, 0);
    check_eq("t1_done", done_cnt - db, 1);
    check_eq("t1_seq_num", seq_num, 1);
    check_eq("t1_busy", busy, 0);

    // tx_ready toggling; enable dropped mid-frame must be ignored.
    b = cap.size(); rb = rd_cnt; db = done_cnt; sb = stab_err;
    enable = 1'b1; src_ready = 1'b1; tx_ready = 1'b0;
    wait_end(1'b1, 0, 1, rb, to, bz);
    enable = 1'b1;
    check_eq("t2_timeout", to, 0);
    repeat (3) @(negedge clk);
    check_eq("t2_len", cap.size() - b, FL);
    for (int i = 0; i < FL; i++) check_eq("t2_byte", cap[b + i], exp2[i]);
    check_eq("t2_stable", stab_err - sb, 0);
    check_eq("t2_rd_pulses", rd_cnt - rb, PB);
    check_eq("t2_done", done_cnt - db, 1);
    check_eq("t2_seq_num", seq_num, 2);

    // src_ready drops after the second payload byte is presented.
    b = cap.size(); rb = rd_cnt; db = done_cnt; ab = abort_cnt;
    src_ready = 1'b1;
    wait_end(1'b0, 2, 0, rb, to, bz);
    check_eq("t3_timeout", to, 0);
    check_eq("t3_busy_after_abort", bz, 0);
    repeat (3) @(negedge clk);
    check_eq("t3_len", cap.size() - b, 7);
    for (int i = 0; i < 7; i++) check_eq("t3_byte", cap[b + i], exp3[i]);
    check_eq("t3_abort", abort_cnt - ab, 1);
    check_eq("t3_done", done_cnt - db, 0);
    check_eq("t3_rd_pulses", rd_cnt - rb, 2);
    check_eq("t3_seq_num", seq_num, 2);

    // Asynchronous reset while a payload byte is pending.
    src_ready = 1'b1;
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (src_rd && tx_valid) begin to = 1'b0; break; end
    end
    check_eq("t4_timeout", to, 0);
    tx_ready = 1'b0;
    check_eq("t4_pay_valid", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t4_src_rd", src_rd, 0);
    check_eq("t4_tx_valid", tx_valid, 0);
    check_eq("t4_tx_data", tx_data, 0);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_seq_num", seq_num, 0);
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b0; src_ready = 1'b1; tx_ready = 1'b1;
    rb = rd_cnt; vb = valid_cnt; bb = busy_cnt;
    repeat (20) @(negedge clk);
    check_eq("t6_no_rd", rd_cnt - rb, 0);
    check_eq("t6_no_valid", valid_cnt - vb, 0);
    check_eq("t6_no_busy", busy_cnt - bb, 0);

    // 257 back-to-back frames: sequence field wraps through 00.
    b = cap.size(); nd = 0; pend = 1'b0; fin = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 10000 && !fin; k++) begin
      @(negedge clk);
      if (pend) begin check_eq("t5_seq_wrap", seq_num, 0); pend = 1'b0; end
      if (frame_done) begin
        nd++;
        if (nd == 256) pend = 1'b1;
        if (nd == 257) begin src_ready = 1'b0; fin = 1'b1; end
      end
    end
    check_eq("t5_timeout", fin, 1);
    repeat (3) @(negedge clk);
    check_eq("t5_len", cap.size() - b, 257 * FL);
    for (int f = 0; f < 257; f++) check_eq("t5_seq_field", cap[b + f * FL + 2], f % 256);
    check_eq("t5_seq_num", seq_num, 1);
    check_eq("t5_rd_gap", gap_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
